// File: rtl/motor_pkg.sv
// Drive-mode codes and bus widths shared by the joystick decoder and the motor block.
package motor_pkg;

    localparam int MODE_W = 4;
    localparam int AXIS_W = 10;

    typedef enum logic [MODE_W-1:0] {
        MODE_STOP     = 4'd0,
        MODE_FORWARD  = 4'd1,
        MODE_BACKWARD = 4'd2,
        MODE_LEFT     = 4'd3,
        MODE_RIGHT    = 4'd4
    } mode_e;

endpackage

// File: rtl/jstk_axis_classify.sv
// Combinational joystick classifier: deadzone around CENTER, then dominant axis (ties go to Y).
module jstk_axis_classify
    import motor_pkg::*;
#(
    parameter int CENTER = 512,
    parameter int DEAD   = 128
) (
    input  logic [AXIS_W-1:0] x_pos,
    input  logic [AXIS_W-1:0] y_pos,
    output mode_e             cls
);

    localparam logic signed [AXIS_W:0] CENTER_S = (AXIS_W+1)'(CENTER);
    localparam logic        [AXIS_W:0] DEAD_U   = (AXIS_W+1)'(DEAD);

    logic signed [AXIS_W:0] dx;
    logic signed [AXIS_W:0] dy;
    logic        [AXIS_W:0] ax;
    logic        [AXIS_W:0] ay;

    always_comb begin
        dx  = $signed({1'b0, x_pos}) - CENTER_S;
        dy  = $signed({1'b0, y_pos}) - CENTER_S;
        ax  = dx[AXIS_W] ? $unsigned(-dx) : $unsigned(dx);
        ay  = dy[AXIS_W] ? $unsigned(-dy) : $unsigned(dy);
        cls = MODE_STOP;
        // Outside the deadzone the dominant magnitude is non-zero, so the sign bit decides direction.
        if (ax <= DEAD_U && ay <= DEAD_U) begin
            cls = MODE_STOP;
        end else if (ay >= ax) begin
            cls = dy[AXIS_W] ? MODE_BACKWARD : MODE_FORWARD;
        end else begin
            cls = dx[AXIS_W] ? MODE_LEFT : MODE_RIGHT;
        end
    end

endmodule

// File: rtl/jstk_mode_decoder.sv
// Debounced joystick-to-drive-mode decoder with sample watchdog and arm gating.
module jstk_mode_decoder
    import motor_pkg::*;
#(
    parameter int CENTER      = 512,
    parameter int DEAD        = 128,
    parameter int DEBOUNCE    = 3,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sample_valid,
    input  logic [AXIS_W-1:0] x_pos,
    input  logic [AXIS_W-1:0] y_pos,
    input  logic              arm,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic              timeout
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYC);

    mode_e            cls;
    mode_e            mode_q, mode_d;
    mode_e            cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             chg_q, chg_d;
    logic             to_q, to_d;

    jstk_axis_classify #(
        .CENTER (CENTER),
        .DEAD   (DEAD)
    ) u_classify (
        .x_pos (x_pos),
        .y_pos (y_pos),
        .cls   (cls)
    );

    always_comb begin
        wd_d   = wd_q;
        mode_d = mode_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sample_valid) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
        // A valid sample clears the watchdog on this edge, so it always beats expiry.
        to_d = (wd_d == WD_MAX);

        if (!arm || to_d) begin
            mode_d = MODE_STOP;
            cand_d = MODE_STOP;
            cnt_d  = '0;
        end else if (sample_valid) begin
            if (cls == cand_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cand_d = cls;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX && cand_d != mode_q) begin
                mode_d = cand_d;
            end
        end
        chg_d = (mode_d != mode_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_q <= MODE_STOP;
            cand_q <= MODE_STOP;
            cnt_q  <= '0;
            wd_q   <= '0;
            chg_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            wd_q   <= wd_d;
            chg_q  <= chg_d;
            to_q   <= to_d;
        end
    end

    assign mode     = mode_q;
    assign mode_chg = chg_q;
    assign timeout  = to_q;

endmodule
